// File: rtl/uart_pkg.sv
// uart_pkg: shared types and helpers for the UART transmitter.
//   uart_tx_state_t : transmitter FSM states
//   bit_ticks()     : clocks per bit, rounded to nearest
package uart_pkg;
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_tx_state_t;

    function automatic int bit_ticks(int clk, int baud);
        return (clk + baud / 2) / baud;
    endfunction
endpackage

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: free-running bit-period counter with synchronous clear.
//   clk_i   in  system clock
//   rst_i   in  asynchronous active-high reset
//   clear_i in  hold counter at zero
//   tick_o  out one-cycle pulse while count equals Ticks-1
module uart_baud_gen #(
    parameter int Ticks = 5208
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    output logic tick_o
);
    localparam int W = $clog2(Ticks);

    logic [W-1:0] cnt_q, cnt_d;

    assign tick_o = cnt_q == W'(Ticks - 1);

    always_comb cnt_d = (clear_i || tick_o) ? '0 : cnt_q + W'(1);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end
endmodule

// File: rtl/uart_tx.sv
// uart_tx: transmit-only UART, 8N(Stop) frames, level request with back-to-back streaming.
//   clock in  system clock, rising edge
//   reset in  asynchronous active-high reset
//   data  in  word to send, sampled at frame start
//   reptx in  transmit request level; frames repeat while high
//   txd   out serial line, idles high
//   cts   out high exactly while idle
module uart_tx
    import uart_pkg::*;
#(
    parameter int Clock = 50000000,
    parameter int Baud  = 9600,
    parameter int Stop  = 1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] data,
    input  logic       reptx,
    output logic       txd,
    output logic       cts
);
    localparam int BitTicks = bit_ticks(Clock, Baud);

    generate
        if (BitTicks < 2 || Stop < 1 || Stop > 8) begin : g_bad_params
            $error("uart_tx: BitTicks must be >= 2 and Stop in 1..8");
        end
    endgenerate

    uart_tx_state_t state_q, state_d;
    logic [7:0]     shreg_q, shreg_d;
    logic [2:0]     bit_q, bit_d;
    logic [2:0]     stop_q, stop_d;
    logic           txd_q, txd_d;
    logic           cts_q, cts_d;
    logic           tick;

    // The counter is held at zero while idle so the start bit gets a full period.
    uart_baud_gen #(.Ticks(BitTicks)) u_baud (
        .clk_i   (clock),
        .rst_i   (reset),
        .clear_i (state_q == IDLE),
        .tick_o  (tick)
    );

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        bit_d   = bit_q;
        stop_d  = stop_q;
        if (state_q == IDLE) begin
            if (reptx) begin
                state_d = START;
                shreg_d = data;
            end
        end else if (tick) begin
            if (state_q == START) begin
                state_d = DATA;
                bit_d   = '0;
            end else if (state_q == DATA) begin
                shreg_d = shreg_q >> 1;
                if (bit_q == 3'd7) begin
                    state_d = STOP;
                    stop_d  = '0;
                end else begin
                    bit_d = bit_q + 3'd1;
                end
            end else if (stop_q == 3'(Stop - 1)) begin
                // Streaming: reload and restart with no idle gap.
                state_d = reptx ? START : IDLE;
                shreg_d = reptx ? data : shreg_q;
            end else begin
                stop_d = stop_q + 3'd1;
            end
        end
        // Outputs are computed from the next state so they come straight from flops.
        txd_d = state_d == START ? 1'b0 : state_d == DATA ? shreg_d[0] : 1'b1;
        cts_d = state_d == IDLE;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            shreg_q <= '0;
            bit_q   <= '0;
            stop_q  <= '0;
            txd_q   <= 1'b1;
            cts_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            bit_q   <= bit_d;
            stop_q  <= stop_d;
            txd_q   <= txd_d;
            cts_q   <= cts_d;
        end
    end

    assign txd = txd_q;
    assign cts = cts_q;
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: randomized self-checking bench for two uart_tx instances (Stop=2 and Stop=4).
module tb_uart_tx;
    localparam int Clock = 1000;
    localparam int Baud  = 150;
    localparam int T     = (Clock + Baud / 2) / Baud;
    localparam int L2    = (9 + 2) * T;
    localparam int L4    = (9 + 4) * T;

    logic       clk   = 1'b0;
    logic       rst   = 1'b1;
    logic       reptx = 1'b0;
    logic [7:0] data  = 8'h00;
    logic       txd2, cts2, txd4, cts4;
    int         checks = 0;
    int         failures = 0;

    always #5 clk = ~clk;

    uart_tx #(.Clock(Clock), .Baud(Baud), .Stop(2)) u2 (
        .clock(clk), .reset(rst), .data(data), .reptx(reptx), .txd(txd2), .cts(cts2)
    );
    uart_tx #(.Clock(Clock), .Baud(Baud), .Stop(4)) u4 (
        .clock(clk), .reset(rst), .data(data), .reptx(reptx), .txd(txd4), .cts(cts4)
    );

    // Line level j clocks into a frame: start bit, data LSB first, then stop bits.
    function automatic logic frame_bit(logic [7:0] d, int j);
        int b = j / T;
        return b == 0 ? 1'b0 : b <= 8 ? d[b-1] : 1'b1;
    endfunction

    // Edge 0 is the first request edge. data is d0 before edge c and d1 from it on;
    // reptx is high for edges 0..dd-1. Frames start at multiples of the frame length
    // while reptx is high there; the frame running when reptx drops still completes.
    task automatic run_frames(input logic [7:0] d0, input logic [7:0] d1,
                              input int c, input int dd, input int n, input string name);
        @(negedge clk);
        data  = d0;
        reptx = 1'b1;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                int len      = i ? L4 : L2;
                int last_end = ((dd + len - 1) / len) * len;
                logic [7:0] fd;
                logic [1:0] exp_v, obs_v;
                fd    = ((k / len) * len >= c) ? d1 : d0;
                exp_v = {k < last_end ? frame_bit(fd, k % len) : 1'b1, k >= last_end};
                obs_v = i ? {txd4, cts4} : {txd2, cts2};
                checks++;
                if (obs_v !== exp_v) begin
                    failures++;
                    $display("FAIL %s stop=%0d cycle=%0d: txd,cts=%b expected %b",
                             name, i ? 4 : 2, k, obs_v, exp_v);
                end
            end
            reptx = (k + 1 < dd);
            data  = (k + 1 >= c) ? d1 : d0;
        end
        reptx = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (10) begin
            @(negedge clk);
            checks++;
            if ({txd2, cts2, txd4, cts4} !== 4'hF) begin
                failures++;
                $display("FAIL reset_hold: txd2,cts2,txd4,cts4=%b expected 1111", {txd2, cts2, txd4, cts4});
            end
        end
        rst = 1'b0;
        repeat (1000) begin
            @(negedge clk);
            checks++;
            if ({txd2, cts2, txd4, cts4} !== 4'hF) begin
                failures++;
                $display("FAIL reset_idle: txd2,cts2,txd4,cts4=%b expected 1111", {txd2, cts2, txd4, cts4});
            end
        end
    endtask

    task automatic test_single_frame();
        run_frames(8'hA5, 8'($urandom), 3 * T, 1, L4 + 20, "single_a5");
        for (int r = 0; r < 3; r++)
            run_frames(8'($urandom), 8'($urandom), 2 * T + r, 1, L4 + 10, "single_rand");
    endtask

    task automatic test_back_to_back();
        run_frames(8'h5A, 8'h5A, L4 * 4, 3 * L4, 4 * L4, "repeat_5a");
        run_frames(8'($urandom), 8'($urandom), $urandom_range(L4 + 1, 2 * L4),
                   $urandom_range(2 * L4, 3 * L4), 4 * L4, "repeat_change");
        run_frames(8'($urandom), 8'($urandom), L2, 2 * L2, 4 * L4, "drop_at_boundary");
        run_frames(8'($urandom), 8'($urandom), L2 - 1, 2 * L2 + 1, 4 * L4, "drop_after_boundary");
    endtask

    task automatic test_mid_frame_reset();
        logic [7:0] d = 8'($urandom);
        @(negedge clk);
        data  = d;
        reptx = 1'b1;
        for (int k = 0; k <= 4 * T + 1; k++) @(negedge clk);
        checks++;
        if ({txd2, txd4} !== {2{d[3]}}) begin
            failures++;
            $display("FAIL reset_mid_bit3: txd2,txd4=%b expected %b", {txd2, txd4}, {2{d[3]}});
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({txd2, cts2, txd4, cts4} !== 4'hF) begin
            failures++;
            $display("FAIL reset_async: txd2,cts2,txd4,cts4=%b expected 1111", {txd2, cts2, txd4, cts4});
        end
        reptx = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (200) begin
            @(negedge clk);
            checks++;
            if ({txd2, cts2, txd4, cts4} !== 4'hF) begin
                failures++;
                $display("FAIL reset_release_idle: txd2,cts2,txd4,cts4=%b expected 1111", {txd2, cts2, txd4, cts4});
            end
        end
        run_frames(8'($urandom), 8'($urandom), T, 1, L4 + 10, "after_reset");
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_mid_frame_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
